// File: rtl/conv_result_reader_pkg.sv
// Purpose: shared constants, state encoding and output payload type for the
//          convolution result read-out path.
// Contents: CONV_ROWS/CONV_COLS/CONV_DW matrix geometry, derived index widths,
//           state_e FSM encoding, rd_out_t registered output payload,
//           flat_idx() row-major element index helper.
package conv_result_reader_pkg;

  localparam int unsigned CONV_ROWS = 4;
  localparam int unsigned CONV_COLS = 4;
  localparam int unsigned CONV_DW   = 8;

  localparam int unsigned CONV_N = CONV_ROWS * CONV_COLS;
  localparam int unsigned ROW_W  = $clog2(CONV_ROWS);
  localparam int unsigned COL_W  = $clog2(CONV_COLS);
  localparam int unsigned IDX_W  = $clog2(CONV_N);
  localparam int unsigned RES_W  = CONV_N * CONV_DW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [CONV_DW-1:0] data;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               valid;
    logic               done;
  } rd_out_t;

  // Row-major flat position of element (row, col) in the captured buffer.
  function automatic logic [IDX_W-1:0] flat_idx(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return IDX_W'(IDX_W'(row) * IDX_W'(CONV_COLS) + IDX_W'(col));
  endfunction

endpackage

// File: rtl/conv_result_reader_if.sv
// Purpose: result-matrix hand-off from convLayer plus the registered read-out bus.
// Signals: res_valid  one-cycle strobe, res_data holds a complete matrix
//          res_data   flattened matrix, element (r,c) at [(r*COLS+c)*DW +: DW]
//          out_data   selected element
//          out_row    row index of out_data
//          out_col    column index of out_data
//          out_valid  out_* hold a captured element
//          done       last element has been stepped past
// Modports: master = matrix producer / display consumer, slave = reader.
interface conv_result_reader_if;
  import conv_result_reader_pkg::*;

  logic                 res_valid;
  logic [RES_W-1:0]     res_data;
  logic [CONV_DW-1:0]   out_data;
  logic [ROW_W-1:0]     out_row;
  logic [COL_W-1:0]     out_col;
  logic                 out_valid;
  logic                 done;

  modport master (
    output res_valid, res_data,
    input  out_data, out_row, out_col, out_valid, done
  );

  modport slave (
    input  res_valid, res_data,
    output out_data, out_row, out_col, out_valid, done
  );

endinterface

// File: rtl/conv_result_reader_btn_edge_sync.sv
// Purpose: bring a raw asynchronous push button into the clk domain and emit a
//          single-cycle pulse on each rising edge of the synchronised level.
// Ports: clk        clock, rising edge
//        rst_n      asynchronous active-low reset, clears all flops
//        btn_raw_i  raw button level
//        pulse_c_o  one-cycle pulse (decoded from flops, no input path)
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic pulse_c_o
);

  logic s1_q, s2_q, s3_q;

  // s1/s2 synchronise, s3 remembers the previous synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= btn_raw_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_c_o = s2_q & ~s3_q;

endmodule

// File: rtl/conv_result_reader.sv
// Purpose: capture one result matrix from convLayer and step through it in
//          row-major order, one element per "next" button press.
// Ports: clk       clock, rising edge
//        rst_n     asynchronous active-low reset
//        next_btn  raw asynchronous button, advance one element per press
//        restart   synchronous level, rewind to (0,0) keeping the buffer
//        bus       conv_result_reader_if.slave: res_valid/res_data in,
//                  out_data/out_row/out_col/out_valid/done out (all registered)
module conv_result_reader
  import conv_result_reader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       next_btn,
  input  logic                       restart,
  conv_result_reader_if.slave        bus
);

  logic               next_pulse_c;
  state_e             state_q, state_d;
  rd_out_t            out_q, out_d;
  logic               cap_c;
  logic [CONV_DW-1:0] buf_q [CONV_N];
  logic [ROW_W-1:0]   nrow_c;
  logic [COL_W-1:0]   ncol_c;
  logic               last_c;

  btn_edge_sync u_next_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw_i (next_btn),
    .pulse_c_o (next_pulse_c)
  );

  // Matrix buffer: whole-matrix write on capture only; contents need no reset.
  always_ff @(posedge clk) begin
    if (cap_c) begin
      for (int k = 0; k < int'(CONV_N); k++) begin
        buf_q[k] <= bus.res_data[k*CONV_DW +: CONV_DW];
      end
    end
  end

  // Successor coordinates, column first with wrap into the next row.
  always_comb begin
    nrow_c = out_q.row;
    ncol_c = out_q.col + COL_W'(1);
    last_c = (out_q.row == ROW_W'(CONV_ROWS - 1)) &&
             (out_q.col == COL_W'(CONV_COLS - 1));
    if (out_q.col == COL_W'(CONV_COLS - 1)) begin
      ncol_c = '0;
      nrow_c = out_q.row + ROW_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Next state / outputs. Priority: capture > restart > next pulse; losers drop.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cap_c   = 1'b0;

    if (bus.res_valid) begin
      // Buffer is not written yet, so element (0,0) comes straight from the bus.
      cap_c       = 1'b1;
      state_d     = ST_SHOW;
      out_d.row   = '0;
      out_d.col   = '0;
      out_d.data  = bus.res_data[CONV_DW-1:0];
      out_d.valid = 1'b1;
      out_d.done  = 1'b0;
    end else if (restart && (state_q != ST_IDLE)) begin
      state_d     = ST_SHOW;
      out_d.row   = '0;
      out_d.col   = '0;
      out_d.data  = buf_q[0];
      out_d.valid = 1'b1;
      out_d.done  = 1'b0;
    end else if (next_pulse_c && (state_q == ST_SHOW)) begin
      if (last_c) begin
        // Index and data hold their final values while done is shown.
        state_d     = ST_DONE;
        out_d.valid = 1'b0;
        out_d.done  = 1'b1;
      end else begin
        out_d.row  = nrow_c;
        out_d.col  = ncol_c;
        out_d.data = buf_q[flat_idx(nrow_c, ncol_c)];
      end
    end
  end

  assign bus.out_data  = out_q.data;
  assign bus.out_row   = out_q.row;
  assign bus.out_col   = out_q.col;
  assign bus.out_valid = out_q.valid;
  assign bus.done      = out_q.done;

endmodule

// File: tb/tb_conv_result_reader.sv
// Purpose: self-checking bench for conv_result_reader; directed scenarios plus
//          randomized matrices and press sequences against a position model.
module tb_conv_result_reader;
  import conv_result_reader_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic next_btn;
  logic restart;

  conv_result_reader_if bus ();

  conv_result_reader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .next_btn (next_btn),
    .restart  (restart),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: captured matrix, current row-major position, flags.
  logic [CONV_DW-1:0] m_buf [CONV_N];
  int                 m_k;
  bit                 m_have;
  bit                 m_fin;
  int                 n_vec = 0;
  int                 n_bad = 0;

  function automatic void m_reset();
    m_k    = 0;
    m_have = 1'b0;
    m_fin  = 1'b0;
  endfunction

  function automatic void m_capture(input logic [RES_W-1:0] d);
    for (int k = 0; k < int'(CONV_N); k++) m_buf[k] = d[k*CONV_DW +: CONV_DW];
    m_k    = 0;
    m_have = 1'b1;
    m_fin  = 1'b0;
  endfunction

  function automatic void m_step();
    if (m_have && !m_fin) begin
      if (m_k == int'(CONV_N) - 1) m_fin = 1'b1;
      else m_k = m_k + 1;
    end
  endfunction

  function automatic void m_rewind();
    if (m_have) begin
      m_k   = 0;
      m_fin = 1'b0;
    end
  endfunction

  task automatic check_all(input string tag);
    logic [CONV_DW-1:0] ed;
    logic [ROW_W-1:0]   er;
    logic [COL_W-1:0]   ec;
    logic               ev, edn;
    er  = ROW_W'(m_k / int'(CONV_COLS));
    ec  = COL_W'(m_k % int'(CONV_COLS));
    ev  = m_have && !m_fin;
    edn = m_fin;
    ed  = m_have ? m_buf[m_k] : '0;
    n_vec++;
    assert (bus.out_valid === ev) else begin
      n_bad++; $error("FAIL %s out_valid got %b exp %b", tag, bus.out_valid, ev);
    end
    n_vec++;
    assert (bus.done === edn) else begin
      n_bad++; $error("FAIL %s done got %b exp %b", tag, bus.done, edn);
    end
    n_vec++;
    assert (bus.out_row === er) else begin
      n_bad++; $error("FAIL %s out_row got %0d exp %0d", tag, bus.out_row, er);
    end
    n_vec++;
    assert (bus.out_col === ec) else begin
      n_bad++; $error("FAIL %s out_col got %0d exp %0d", tag, bus.out_col, ec);
    end
    n_vec++;
    assert (bus.out_data === ed) else begin
      n_bad++; $error("FAIL %s out_data got %h exp %h", tag, bus.out_data, ed);
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++; $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic capture(input logic [RES_W-1:0] d, input string tag);
    bus.res_data  = d;
    bus.res_valid = 1'b1;
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    m_capture(d);
    check_all(tag);
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    m_rewind();
    check_all(tag);
  endtask

  // One press held for 'hold' cycles; unchanged after edge 2, advanced at edge 3.
  task automatic press(input int hold, input string tag);
    int last_e;
    last_e = ((hold > 3) ? hold : 3) + 3;
    next_btn = 1'b1;
    for (int e = 1; e <= last_e; e++) begin
      @(posedge clk); #1;
      if (e == hold) next_btn = 1'b0;
      if (e == 2) check_all({tag, "_pre"});
      if (e == 3) begin
        m_step();
        check_all({tag, "_adv"});
      end
    end
  endtask

  function automatic logic [RES_W-1:0] inc_matrix();
    logic [RES_W-1:0] d;
    for (int k = 0; k < int'(CONV_N); k++) d[k*CONV_DW +: CONV_DW] = CONV_DW'(8'h10 + k);
    return d;
  endfunction

  function automatic logic [RES_W-1:0] rand_matrix();
    logic [RES_W-1:0] d;
    for (int k = 0; k < int'(CONV_N); k++) d[k*CONV_DW +: CONV_DW] = CONV_DW'($urandom);
    return d;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    next_btn      = 1'b0;
    restart       = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    m_reset();
    @(posedge clk); #1;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IDLE ignores presses and restart
    press(2, "idle_press");
    do_restart("idle_restart");

    // 1: capture, element (0,0) one cycle later
    capture(inc_matrix(), "t1_cap");
    check_eq("t1_data", 32'(bus.out_data), 32'h10);

    // 2: three presses held 5 cycles each
    for (int i = 0; i < 3; i++) press(5, "t2_press");
    check_eq("t2_col", 32'(bus.out_col), 32'd3);
    check_eq("t2_row", 32'(bus.out_row), 32'd0);
    check_eq("t2_data", 32'(bus.out_data), 32'h13);

    // 3: walk the whole matrix and past the end
    capture(inc_matrix(), "t3_cap");
    for (int i = 0; i < 15; i++) press(1 + (i % 4), "t3_press");
    check_eq("t3_row15", 32'(bus.out_row), 32'd3);
    check_eq("t3_col15", 32'(bus.out_col), 32'd3);
    check_eq("t3_data15", 32'(bus.out_data), 32'h1F);
    press(2, "t3_p16");
    check_eq("t3_valid16", 32'(bus.out_valid), 32'd0);
    check_eq("t3_done16", 32'(bus.done), 32'd1);
    press(3, "t3_p17");
    do_restart("t3_restart_done");

    // 4: restart beats a coincident next pulse at (2,1)
    for (int i = 0; i < 9; i++) press(1, "t4_walk");
    check_eq("t4_at21", 32'({bus.out_row, bus.out_col}), 32'({2'd2, 2'd1}));
    next_btn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    m_rewind();
    check_all("t4_restart");
    check_eq("t4_data", 32'(bus.out_data), 32'h10);
    next_btn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_all("t4_dropped");

    // 5: capture beats a coincident next pulse
    press(2, "t5_pre_move");
    next_btn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    capture({CONV_N{8'hA5}}, "t5_cap");
    check_eq("t5_data", 32'(bus.out_data), 32'hA5);
    next_btn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_all("t5_dropped");

    // 6: asynchronous reset mid-readout
    press(1, "t6_walk");
    press(1, "t6_walk");
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all("t6_async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    press(2, "t6_after_rst");
    press(4, "t6_after_rst");
    do_restart("t6_restart");
    capture(rand_matrix(), "t6_recap");

    // Randomized matrices, hold times, and occasional restarts
    for (int r = 0; r < 6; r++) begin
      int n;
      capture(rand_matrix(), "rnd_cap");
      n = int'($urandom_range(4, 20));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) do_restart("rnd_restart");
        else press(int'($urandom_range(1, 6)), "rnd_press");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
